// File: rtl/signed_add_rr_arbiter_pkg.sv
// Shared constants, operand type and the signed add-with-overflow helper
// for the round-robin shared adder block.
package signed_add_arb_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_W     = 4;
    localparam int DEF_CNT_W = 8;

    typedef logic signed [DEF_W-1:0] operand_t;

    // Returns {ovf, sum}. Overflow means both operands share a sign and
    // the truncated sum has the opposite sign.
    function automatic logic [DEF_W:0] add_ovf(input operand_t a, input operand_t b);
        operand_t sum;
        logic     ovf;
        sum = a + b;
        ovf = (a[DEF_W-1] == b[DEF_W-1]) && (sum[DEF_W-1] != a[DEF_W-1]);
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/signed_add_rr_arbiter_if.sv
// Requester and result bus of the shared signed adder. Clients drive the
// master side and the arbiter sits on the slave side.
interface signed_add_rr_arbiter_if
    import signed_add_arb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = $clog2(N)
);

    logic [N-1:0]     req;
    logic [N*W-1:0]   a;
    logic [N*W-1:0]   b;
    logic [N-1:0]     gnt;
    logic             res_vld;
    logic             res_rdy;
    logic [ID_W-1:0]  res_id;
    logic [W-1:0]     res_sum;
    logic             res_ovf;
    logic [CNT_W-1:0] ovf_cnt;

    modport master (
        output req, a, b, res_rdy,
        input  gnt, res_vld, res_id, res_sum, res_ovf, ovf_cnt
    );

    modport slave (
        input  req, a, b, res_rdy,
        output gnt, res_vld, res_id, res_sum, res_ovf, ovf_cnt
    );

endinterface

// File: rtl/signed_add_rr_arbiter_arb.sv
// Combinational round-robin picker: first active request at or above ptr,
// wrapping from N-1 back to 0. Produces nothing while en is low.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any_gnt
);

    // Walk the requesters starting at ptr and grant the first one found.
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int off = 0; off < N; off++) begin
            idx = ID_W'((int'(ptr) + off) % N);
            if (en && !any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/signed_add_rr_arbiter.sv
// Shares one signed adder among N requesters with round-robin arbitration,
// a registered result stage with backpressure and a saturating count of
// accepted overflow results.
module signed_add_rr_arbiter
    import signed_add_arb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = $clog2(N)
) (
    input logic                    clk,
    input logic                    rst,
    signed_add_rr_arbiter_if.slave bus
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  next_ptr;
    logic [N-1:0]     gnt;
    logic             any_gnt;
    logic             en;
    logic             arb_en;
    operand_t         op_a;
    operand_t         op_b;
    logic [W:0]       add_res;
    logic             accept;

    logic             res_vld_q;
    logic [ID_W-1:0]  res_id_q;
    logic [W-1:0]     res_sum_q;
    logic             res_ovf_q;
    logic [CNT_W-1:0] ovf_cnt_q;

    // The output stage can take a new result when it is empty or draining.
    // Grants are suppressed during reset so nobody sees a phantom handshake.
    assign en     = !res_vld_q || bus.res_rdy;
    assign arb_en = en && !rst;
    assign accept = res_vld_q && bus.res_rdy;

    rr_arbiter #(
        .N    (N),
        .ID_W (ID_W)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign op_a     = bus.a[gnt_idx*W +: W];
    assign op_b     = bus.b[gnt_idx*W +: W];
    assign add_res  = add_ovf(op_a, op_b);
    assign next_ptr = (gnt_idx == ID_W'(N-1)) ? '0 : gnt_idx + 1'b1;

    assign bus.gnt     = gnt;
    assign bus.res_vld = res_vld_q;
    assign bus.res_id  = res_id_q;
    assign bus.res_sum = res_sum_q;
    assign bus.res_ovf = res_ovf_q;
    assign bus.ovf_cnt = ovf_cnt_q;

    // Result register: load the winner, go empty when enabled with no
    // winner, hold everything while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vld_q <= 1'b0;
            res_id_q  <= '0;
            res_sum_q <= '0;
            res_ovf_q <= 1'b0;
        end else if (en) begin
            if (any_gnt) begin
                res_vld_q <= 1'b1;
                res_id_q  <= gnt_idx;
                res_sum_q <= add_res[W-1:0];
                res_ovf_q <= add_res[W];
            end else begin
                res_vld_q <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves just past each granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (any_gnt) begin
            ptr <= next_ptr;
        end
    end

    // Count overflow results as they leave, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (accept && res_ovf_q && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_signed_add_rr_arbiter.sv
// Self-checking bench for signed_add_rr_arbiter with a behavioural
// scoreboard of grants, results and the overflow counter.
module tb_signed_add_rr_arbiter;

    typedef struct {
        int         id;
        logic [3:0] sum;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst;

    int pass_cnt  = 0;
    int check_cnt = 0;

    exp_t sb[$];
    int   gnt_log[$];

    logic       m_vld;
    int         m_ptr;
    int         m_cnt;
    logic       m_en;
    int         m_k;
    logic [3:0] m_gnt;
    exp_t       m_item;
    exp_t       m_front;

    signed_add_rr_arbiter_if #(.N(4), .W(4), .CNT_W(8)) bus ();

    signed_add_rr_arbiter #(.N(4), .W(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] av,
                                 input logic [15:0] bv, input logic rdy);
        bus.req     = r;
        bus.a       = av;
        bus.b       = bv;
        bus.res_rdy = rdy;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int pickReq(input logic [3:0] r, input int p);
        for (int off = 0; off < 4; off++) begin
            if (r[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    // Mid-cycle scoreboard: compare outputs with the model, then advance the model.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_vld = 1'b0;
            m_ptr = 0;
            m_cnt = 0;
            checkOutput("rst_vld", bus.res_vld, 0);
            checkOutput("rst_gnt", bus.gnt, 0);
            checkOutput("rst_cnt", bus.ovf_cnt, 0);
        end else begin
            checkOutput("res_vld", bus.res_vld, m_vld);
            if (m_vld) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_depth", 0, 1);
                end else begin
                    m_front = sb[0];
                    checkOutput("res_id", bus.res_id, m_front.id);
                    checkOutput("res_sum", bus.res_sum, m_front.sum);
                    checkOutput("res_ovf", bus.res_ovf, m_front.ovf);
                end
            end
            checkOutput("ovf_cnt", bus.ovf_cnt, m_cnt);
            m_en  = !m_vld || bus.res_rdy;
            m_k   = m_en ? pickReq(bus.req, m_ptr) : -1;
            m_gnt = (m_k >= 0) ? (4'b0001 << m_k) : 4'b0000;
            checkOutput("gnt", bus.gnt, m_gnt);
            if (m_vld && bus.res_rdy && sb.size() > 0) begin
                m_front = sb.pop_front();
                if (m_front.ovf && m_cnt != 255) m_cnt++;
            end
            if (m_en) begin
                if (m_k >= 0) begin
                    int s;
                    logic [3:0] av;
                    logic [3:0] bv;
                    av = bus.a[m_k*4 +: 4];
                    bv = bus.b[m_k*4 +: 4];
                    s  = $signed(av) + $signed(bv);
                    m_item.id  = m_k;
                    m_item.sum = s[3:0];
                    m_item.ovf = (s > 7) || (s < -8);
                    sb.push_back(m_item);
                    gnt_log.push_back(m_k);
                    m_vld = 1'b1;
                    m_ptr = (m_k + 1) % 4;
                end else begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    initial begin
        int exp_seq5[5] = '{3, 0, 0, 0, 0};
        rst = 1'b1;
        applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic add through requester 0
        applyStimulus(4'b0001, 16'h0003, 16'h0002, 1'b1);
        #1 checkOutput("t1_gnt", bus.gnt, 4'b0001);
        stepCycles(1);
        checkOutput("t1_vld", bus.res_vld, 1);
        checkOutput("t1_id", bus.res_id, 0);
        checkOutput("t1_sum", bus.res_sum, 5);
        checkOutput("t1_ovf", bus.res_ovf, 0);
        applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
        stepCycles(1);

        // Positive then minimum-negative overflow
        applyStimulus(4'b0001, 16'h0007, 16'h0001, 1'b1);
        stepCycles(1);
        checkOutput("t2_pos_sum", bus.res_sum, 4'h8);
        checkOutput("t2_pos_ovf", bus.res_ovf, 1);
        applyStimulus(4'b0001, 16'h0008, 16'h0008, 1'b1);
        stepCycles(1);
        checkOutput("t2_neg_sum", bus.res_sum, 0);
        checkOutput("t2_neg_ovf", bus.res_ovf, 1);
        checkOutput("t2_cnt1", bus.ovf_cnt, 1);
        applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
        stepCycles(1);
        checkOutput("t2_cnt2", bus.ovf_cnt, 2);

        // Grant requester 3 so the pointer wraps to 0
        applyStimulus(4'b1000, 16'h1000, 16'h1000, 1'b1);
        stepCycles(1);

        // Round-robin with all requesters active
        gnt_log.delete();
        applyStimulus(4'b1111, 16'h4321, 16'h7654, 1'b1);
        stepCycles(8);
        checkOutput("t3_len", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
            checkOutput("t3_seq", gnt_log[i], i % 4);
        end
        applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
        stepCycles(2);

        // Backpressure with requesters 1 and 2 waiting
        applyStimulus(4'b0110, 16'h0D50, 16'h0E30, 1'b0);
        stepCycles(1);
        stepCycles(5);
        checkOutput("t4_stall_gnt", bus.gnt, 0);
        checkOutput("t4_stall_id", bus.res_id, 1);
        checkOutput("t4_stall_vld", bus.res_vld, 1);
        applyStimulus(4'b0110, 16'h0D50, 16'h0E30, 1'b1);
        #1 checkOutput("t4_gnt", bus.gnt, 4'b0100);
        stepCycles(1);
        checkOutput("t4_sum", bus.res_sum, 4'hB);

        // Wrap from 3 to 0, then back-to-back grants to a lone requester
        gnt_log.delete();
        applyStimulus(4'b1001, 16'h2001, 16'h3001, 1'b1);
        stepCycles(2);
        applyStimulus(4'b0001, 16'h0004, 16'h0004, 1'b1);
        stepCycles(3);
        checkOutput("t5_len", gnt_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
            checkOutput("t5_seq", gnt_log[i], exp_seq5[i]);
        end
        applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
        stepCycles(2);

        // Asynchronous reset while a result is stalled
        applyStimulus(4'b0110, 16'h0D50, 16'h0E30, 1'b0);
        stepCycles(2);
        checkOutput("t6_pre_vld", bus.res_vld, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_vld", bus.res_vld, 0);
        checkOutput("t6_cnt", bus.ovf_cnt, 0);
        checkOutput("t6_gnt", bus.gnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(4'b1111, 16'h1111, 16'h1111, 1'b1);
        #1 checkOutput("t6_restart_gnt", bus.gnt, 4'b0001);
        stepCycles(1);
        checkOutput("t6_restart_id", bus.res_id, 0);
        applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
        stepCycles(2);

        // Drive enough overflows to saturate the counter
        applyStimulus(4'b0001, 16'h0007, 16'h0001, 1'b1);
        stepCycles(260);
        applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
        stepCycles(2);
        checkOutput("sat_cnt", bus.ovf_cnt, 255);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
